uart_rx: RTL

- 8N1 UART receiver that sits directly upstream of the peripheral block's UART receive register.
- Synchronizes the raw `rxd` pin and recovers bytes by sampling at mid-bit.
- Presents each byte with a one-cycle valid pulse plus a sticky ready flag. The peripheral clears the flag with a read acknowledge.
- Runs on the divided CPU clock `clk`.

---
 rtl/uart_rx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, sticky ready/overrun/framing flags.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each bit centre.
module uart_rx #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ready,
    output logic       rx_overrun,
    output logic       frame_err,
    output logic       rx_busy
);

`ifdef UART_RX_MAJORITY_EN
    // Decision lands one cycle past the nominal target, so the counter must reach CLKS_PER_BIT.
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned SLIP  = 1;
`else
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned SLIP  = 0;
`endif

    localparam logic [CNT_W-1:0] START_DONE = CNT_W'(CLKS_PER_BIT / 2 - 1 + SLIP);
    localparam logic [CNT_W-1:0] BIT_DONE   = CNT_W'(CLKS_PER_BIT - 1 + SLIP);
    localparam logic [CNT_W-1:0] CNT_RESUME = CNT_W'(SLIP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       sync_q, sync_d;
    logic             rxs_prev_q, rxs_prev_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_ready_q, rx_ready_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             rxs;
    logic             bit_s;
    logic             done_ok;
    logic             ferr_ev;

    assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    // hist_q holds rxs from the two cycles before the decision cycle.
    always_comb begin
        hist_d = {hist_q[0], rxs};
        bit_s  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    always_comb begin
        bit_s = rxs;
    end
`endif

    // Receive FSM and byte assembly.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        sync_d     = {sync_q[0], rxd};
        rxs_prev_d = rxs;
        done_ok    = 1'b0;
        ferr_ev    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == START_DONE) begin
                    if (!bit_s) begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_RESUME;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == BIT_DONE) begin
                    shift_d = {bit_s, shift_q[7:1]};
                    cnt_d   = CNT_RESUME;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == BIT_DONE) begin
                    cnt_d = '0;
                    if (bit_s) begin
                        done_ok = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_ev = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky flags: a new event in the same cycle as an ack wins over the clear.
    always_comb begin
        rx_data_d    = done_ok ? shift_q : rx_data_q;
        rx_valid_d   = done_ok;
        rx_ready_d   = done_ok | (rx_ready_q & ~rx_ack);
        rx_overrun_d = (done_ok & rx_ready_q & ~rx_ack) | (rx_overrun_q & ~rx_ack);
        frame_err_d  = ferr_ev | (frame_err_q & ~rx_ack);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            sync_q       <= 2'b11;
            rxs_prev_q   <= 1'b1;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_ready_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            sync_q       <= sync_d;
            rxs_prev_q   <= rxs_prev_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_ready_q   <= rx_ready_d;
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_ready   = rx_ready_q;
    assign rx_overrun = rx_overrun_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != ST_IDLE);

endmodule
